neopixel_frame_feeder: RTL and testbench
========================================

Name: neopixel_frame_feeder

Overview:
- Upstream stage of neopixel_tx_fsm: holds one frame of GRB pixel colours and streams it word by word on the transmitter's rd_next requests.
- Drives neo_dIn, rgb_msgTyp and empty_flg of the transmitter.
- Applies a per-frame global brightness scale.
- Appends latch (reset-gap) words so the strip latches after every frame; replaces ad-hoc colour registers and index counters in top-level designs.

Parameters:
- NUM_PIXELS, 18: pixels per frame, range 1..32.
- ADDR_W, 5: width of wr_addr; 2**ADDR_W >= NUM_PIXELS.
- LATCH_WORDS, 2: msgTyp=0 words sent after the last pixel, range 1..15.

Ports:
- clk  input  1  system clock (20.46 MHz internal oscillator)
- rst  input  1  reset, asynchronous, active-low
- wr_en  input  1  write strobe for pixel memory
- wr_addr  input  ADDR_W  pixel index to write
- wr_data  input  24  pixel colour {G[23:16], R[15:8], B[7:0]}
- brightness  input  8  global scale, 255 = full
- frame_go  input  1  one-cycle pulse: request one frame transmission
- auto_repeat  input  1  1 = restart the frame immediately after the latch words
- rd_next  input  1  one-cycle pulse from transmitter: current word consumed
- neo_dIn  output  24  current word to transmitter
- rgb_msgTyp  output  1  1 = pixel data word, 0 = latch word
- empty_flg  output  1  1 = nothing to send
- busy  output  1  1 in DATA or LATCH
- frame_done  output  1  one-cycle pulse when the last latch word is consumed

Behaviour:
- Reset (rst low, async):
  - State = IDLE; pixel memory all 0; pending = 0.
  - neo_dIn = 0, rgb_msgTyp = 0, empty_flg = 1, busy = 0, frame_done = 0.
- Pixel memory:
  - NUM_PIXELS x 24 register array; write on clk edge when wr_en is high.
  - wr_addr >= NUM_PIXELS: write ignored.
  - Writes are accepted in every state.
  - Write and fetch of the same address in the same cycle: the fetch returns the old value.
- Scaling, per channel: out = (ch * (brightness + 1)) >> 8, 16-bit product, upper 8 bits kept.
  - brightness = 255: identity. brightness = 0: output 0.
  - brightness is sampled into scale_q on frame start and held constant for the whole frame.
- Output register: neo_dIn and rgb_msgTyp are registered. A new word is visible the cycle after the event that loads it.
- FSM states: IDLE, DATA, LATCH. Pixel index idx has width ADDR_W. Latch counter lcnt has 4 bits.
- IDLE:
  - empty_flg = 1, rgb_msgTyp = 0, neo_dIn = 0.
  - On frame_go: capture scale_q, load scaled pixel 0, idx = 0, go to DATA.
  - In the next cycle empty_flg = 0, rgb_msgTyp = 1, busy = 1.
  - rd_next in IDLE is ignored.
- DATA, on rd_next:
  - idx < NUM_PIXELS-1: idx + 1, load the scaled pixel at idx + 1.
  - idx = NUM_PIXELS-1: go to LATCH, lcnt = LATCH_WORDS-1, neo_dIn = 0, rgb_msgTyp = 0.
- LATCH, on rd_next:
  - lcnt > 0: lcnt - 1; neo_dIn stays 0.
  - lcnt = 0: pulse frame_done. Then:
    - If auto_repeat or pending: clear pending, re-capture brightness, load pixel 0, go to DATA. No IDLE cycle occurs; empty_flg stays 0.
    - Otherwise go to IDLE.
- frame_go while busy sets pending (one deep; extra pulses are absorbed). frame_go coinciding with frame end counts as pending.
- rd_next spacing: the transmitter guarantees at least 2 cycles between pulses. Back-to-back pulses need not be supported.
- Words per frame: exactly NUM_PIXELS + LATCH_WORDS rd_next pulses.
- Async reset mid-frame aborts immediately to reset values. The transmitter sees empty_flg = 1.

Decomposition:
- Shared package neopixel_pkg holds:
  - PIXEL_W = 24 and the GRB field offsets.
  - Msg-type encodings MSG_DATA = 1 and MSG_LATCH = 0.
  - State encodings IDLE = 2'd0, DATA = 2'd1, LATCH = 2'd2.
- One natural sub-module, neopixel_scale: combinational 3-channel 8x9 multiply-and-shift. It is reusable by other colour sources.

Test Plan:
- Reset, then write pixels 0..17 = 24'h100000 + i, brightness = 255, frame_go. Pulse rd_next every 30 cycles -> neo_dIn sequence 100000..100011 with msgTyp = 1, then two words of 0 with msgTyp = 0. frame_done pulses once after word 20. Then IDLE with empty_flg = 1.
- Scaling: pixel 0 = 24'hFF8001. brightness = 127 -> neo_dIn = 24'h7F4000. brightness = 0 -> 24'h000000.
- Change brightness and rewrite pixel 5 mid-frame, after pixel 5 was sent -> the rest of the frame uses the old scale. The next frame shows the new pixel 5 at the new scale.
- Write and fetch collision: wr_en to idx 3 in the same cycle as the rd_next that loads idx 3 -> the old value is sent.
- auto_repeat = 1 -> after the last latch word, pixel 0 is loaded on the next edge with empty_flg continuously 0. frame_go during a frame with auto_repeat = 0 -> exactly one extra frame.
- Assert rst low at pixel 9 -> outputs reset asynchronously (empty_flg = 1, neo_dIn = 0) and memory reads 0. After release, frame_go sends 18 zero words.

Source files
------------

// File: rtl/neopixel_pkg.sv
// Shared types and constants for the NeoPixel colour path.
// GRB word layout, message-type encodings and feeder FSM states.
package neopixel_pkg;

   localparam int PIXEL_W = 24;
   localparam int G_LSB   = 16;
   localparam int R_LSB   = 8;
   localparam int B_LSB   = 0;

   localparam logic MSG_DATA  = 1'b1;
   localparam logic MSG_LATCH = 1'b0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      LATCH = 2'd2
   } state_t;

endpackage

// File: rtl/neopixel_scale.sv
// Combinational brightness scaler for one GRB pixel.
// Each channel becomes (ch * (scale + 1)) >> 8.
module neopixel_scale
   import neopixel_pkg::*;
(
   input  logic [PIXEL_W-1:0] color,
   input  logic [7:0]         scale,
   output logic [PIXEL_W-1:0] scaled
);

   logic [8:0] mult;

   assign mult = {1'b0, scale} + 9'd1;

   // 8x9 multiply per channel, keeping the upper byte of the product
   for (genvar c = 0; c < 3; c++) begin : g_ch
      assign scaled[c*8 +: 8] =
         8'(({8'd0, color[c*8 +: 8]} * {7'd0, mult}) >> 8);
   end

endmodule

// File: rtl/neopixel_frame_feeder.sv
// Frame buffer and word sequencer ahead of the NeoPixel transmitter.
// Streams scaled pixels then latch words, one per rd_next request.
module neopixel_frame_feeder
   import neopixel_pkg::*;
#(
   parameter int NUM_PIXELS  = 18,
   parameter int ADDR_W      = 5,
   parameter int LATCH_WORDS = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [PIXEL_W-1:0] wr_data,
   input  logic [7:0]         brightness,
   input  logic               frame_go,
   input  logic               auto_repeat,
   input  logic               rd_next,
   output logic [PIXEL_W-1:0] neo_dIn,
   output logic               rgb_msgTyp,
   output logic               empty_flg,
   output logic               busy,
   output logic               frame_done
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PIXELS - 1);
   localparam logic [ADDR_W:0]   NPIX = (ADDR_W + 1)'(NUM_PIXELS);
   localparam logic [3:0]        LINIT = 4'(LATCH_WORDS - 1);

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    idx_q, idx_d;
   logic [ADDR_W-1:0]    fetch_addr;
   logic [3:0]           lcnt_q, lcnt_d;
   logic [7:0]           scale_q, scale_d;
   logic [7:0]           scale_sel;
   logic                 pend_q, pend_d;
   logic                 done_q, done_d;
   logic                 msg_q, msg_d;
   logic [PIXEL_W-1:0]   word_q, word_d;
   logic [PIXEL_W-1:0]   rd_pix, scaled;
   logic [PIXEL_W-1:0]   mem [NUM_PIXELS];
   logic                 last_word, start;

   // A frame starts from IDLE, or back-to-back when the last latch
   // word goes and a repeat is wanted (auto, queued, or right now).
   assign last_word = (state_q == LATCH) && rd_next
                      && (lcnt_q == 4'd0);
   assign start = ((state_q == IDLE) && frame_go)
                  || (last_word
                      && (auto_repeat || pend_q || frame_go));

   // Starting a frame fetches pixel 0 with the live brightness,
   // since scale_q is only captured on that same edge.
   assign fetch_addr = start ? '0 : idx_q + 1'b1;
   assign scale_sel  = start ? brightness : scale_q;
   assign rd_pix     = ({1'b0, fetch_addr} < NPIX)
                       ? mem[fetch_addr] : '0;

   neopixel_scale u_scale (
      .color  (rd_pix),
      .scale  (scale_sel),
      .scaled (scaled)
   );

   // Pixel memory: writes always allowed, out-of-range ignored
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_PIXELS; i++) mem[i] <= '0;
      end else if (wr_en && ({1'b0, wr_addr} < NPIX)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Next-state and next-word logic
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      lcnt_d  = lcnt_q;
      scale_d = scale_q;
      word_d  = word_q;
      msg_d   = msg_q;
      done_d  = 1'b0;
      pend_d  = pend_q | (frame_go && (state_q != IDLE));
      unique case (state_q)
         IDLE: begin
            word_d = '0;
            msg_d  = MSG_LATCH;
         end
         DATA: begin
            if (rd_next) begin
               if (idx_q == LAST) begin
                  state_d = LATCH;
                  lcnt_d  = LINIT;
                  word_d  = '0;
                  msg_d   = MSG_LATCH;
               end else begin
                  idx_d  = idx_q + 1'b1;
                  word_d = scaled;
                  msg_d  = MSG_DATA;
               end
            end
         end
         LATCH: begin
            if (rd_next) begin
               if (lcnt_q != 4'd0) begin
                  lcnt_d = lcnt_q - 4'd1;
               end else begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (start) begin
         state_d = DATA;
         idx_d   = '0;
         scale_d = brightness;
         word_d  = scaled;
         msg_d   = MSG_DATA;
         pend_d  = 1'b0;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         lcnt_q  <= '0;
         scale_q <= '0;
         pend_q  <= 1'b0;
         done_q  <= 1'b0;
         msg_q   <= MSG_LATCH;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         lcnt_q  <= lcnt_d;
         scale_q <= scale_d;
         pend_q  <= pend_d;
         done_q  <= done_d;
         msg_q   <= msg_d;
         word_q  <= word_d;
      end
   end

   assign neo_dIn    = word_q;
   assign rgb_msgTyp = msg_q;
   assign empty_flg  = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign frame_done = done_q;

endmodule

// File: tb/tb_neopixel_frame_feeder.sv
// Directed bench for neopixel_frame_feeder.
// Hand-computed expected words; outputs sampled on falling edges.
module tb_neopixel_frame_feeder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [23:0] wr_data = '0;
   logic [7:0]  brightness = '0;
   logic        frame_go = 1'b0;
   logic        auto_repeat = 1'b0;
   logic        rd_next = 1'b0;
   logic [23:0] neo_dIn;
   logic        rgb_msgTyp;
   logic        empty_flg;
   logic        busy;
   logic        frame_done;

   int n_chk = 0;
   int n_pass = 0;
   int done_cnt = 0;
   int d0 = 0;
   logic mon = 1'b0;
   logic seen_empty = 1'b0;

   neopixel_frame_feeder #(
      .NUM_PIXELS  (18),
      .ADDR_W      (5),
      .LATCH_WORDS (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .brightness  (brightness),
      .frame_go    (frame_go),
      .auto_repeat (auto_repeat),
      .rd_next     (rd_next),
      .neo_dIn     (neo_dIn),
      .rgb_msgTyp  (rgb_msgTyp),
      .empty_flg   (empty_flg),
      .busy        (busy),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done) done_cnt++;
      if (mon && empty_flg) seen_empty = 1'b1;
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic wr(input logic [4:0] a, input logic [23:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic go();
      @(negedge clk) frame_go = 1'b1;
      @(negedge clk) frame_go = 1'b0;
   endtask

   task automatic rd();
      @(negedge clk) rd_next = 1'b1;
      @(negedge clk) rd_next = 1'b0;
      @(negedge clk);
   endtask

   task automatic rd_n(input int n);
      repeat (n) rd();
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_word", {rgb_msgTyp, neo_dIn}, 32'h0);
      chk("rst_empty", 32'(empty_flg), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      rst = 1'b1;

      // basic frame at full brightness
      for (int i = 0; i < 18; i++) wr(5'(i), 24'h100000 + 24'(i));
      brightness = 8'd255;
      go();
      chk("start_empty", 32'(empty_flg), 32'd0);
      chk("start_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 18; i++) begin
         chk("px", {rgb_msgTyp, neo_dIn}, 32'h1100000 + 32'(i));
         rd();
      end
      chk("latch0", {rgb_msgTyp, neo_dIn}, 32'h0);
      rd();
      chk("latch1", {rgb_msgTyp, neo_dIn}, 32'h0);
      chk("latch1_busy", 32'(busy), 32'd1);
      chk("no_early_done", 32'(done_cnt), 32'd0);
      rd();
      chk("done_once", 32'(done_cnt), 32'd1);
      chk("idle_empty", 32'(empty_flg), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);

      // scaling
      wr(5'd0, 24'hFF8001);
      brightness = 8'd127;
      go();
      chk("scale127", {rgb_msgTyp, neo_dIn}, 32'h17F4000);
      rd_n(20);
      brightness = 8'd0;
      go();
      chk("scale0", {rgb_msgTyp, neo_dIn}, 32'h1000000);
      rd_n(20);

      // brightness and pixel 5 change mid-frame
      brightness = 8'd127;
      go();
      rd_n(5);
      chk("mid_p5", {rgb_msgTyp, neo_dIn}, 32'h1080002);
      rd();
      brightness = 8'd255;
      wr(5'd5, 24'h00FF00);
      rd();
      chk("mid_p7_old", {rgb_msgTyp, neo_dIn}, 32'h1080003);
      rd_n(13);
      chk("mid_idle", 32'(empty_flg), 32'd1);
      go();
      chk("new_p0", {rgb_msgTyp, neo_dIn}, 32'h1FF8001);
      rd_n(5);
      chk("new_p5", {rgb_msgTyp, neo_dIn}, 32'h100FF00);
      rd_n(15);

      // write/fetch collision returns old value
      go();
      rd_n(2);
      chk("col_p2", {rgb_msgTyp, neo_dIn}, 32'h1100002);
      @(negedge clk);
      rd_next = 1'b1; wr_en = 1'b1;
      wr_addr = 5'd3; wr_data = 24'hAAAAAA;
      @(negedge clk);
      rd_next = 1'b0; wr_en = 1'b0;
      @(negedge clk);
      chk("col_old", {rgb_msgTyp, neo_dIn}, 32'h1100003);
      rd_n(17);

      // auto repeat
      auto_repeat = 1'b1;
      go();
      rd_n(19);
      seen_empty = 1'b0;
      mon = 1'b1;
      d0 = done_cnt;
      rd();
      chk("ar_p0", {rgb_msgTyp, neo_dIn}, 32'h1FF8001);
      rd_n(3);
      chk("ar_p3_new", {rgb_msgTyp, neo_dIn}, 32'h1AAAAAA);
      mon = 1'b0;
      chk("ar_no_empty", 32'(seen_empty), 32'd0);
      chk("ar_done", 32'(done_cnt - d0), 32'd1);
      auto_repeat = 1'b0;
      rd_n(17);
      chk("ar_idle", 32'(empty_flg), 32'd1);

      // pending frame_go, extra pulse absorbed
      d0 = done_cnt;
      go();
      rd_n(5);
      go();
      go();
      rd_n(15);
      chk("pend_p0", {rgb_msgTyp, neo_dIn}, 32'h1FF8001);
      chk("pend_busy", 32'(empty_flg), 32'd0);
      rd_n(20);
      chk("pend_idle", 32'(empty_flg), 32'd1);
      chk("pend_done", 32'(done_cnt - d0), 32'd2);

      // async reset mid-frame
      go();
      rd_n(9);
      #2 rst = 1'b0;
      #1;
      chk("arst_empty", 32'(empty_flg), 32'd1);
      chk("arst_word", {rgb_msgTyp, neo_dIn}, 32'h0);
      chk("arst_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      go();
      for (int i = 0; i < 18; i++) begin
         chk("zero_px", {rgb_msgTyp, neo_dIn}, 32'h1000000);
         rd();
      end
      rd_n(2);
      chk("final_idle", 32'(empty_flg), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
